// File: rtl/mul_share_pkg.sv
// mul_share_pkg: state encoding, partial-product shifts and sizing for mul_share_seq (MUL_SHARE_FULL64_EN selects the 64-bit build)
package mul_share_pkg;
`ifdef MUL_SHARE_FULL64_EN
    localparam int NPP = 4;
    localparam int ACC_W = 64;
`else
    localparam int NPP = 3;
    localparam int ACC_W = 32;
`endif
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t RESP = 2'd3;
    function automatic int unsigned pp_shift(input logic [1:0] i);
        return (i == 2'd0) ? 32'd0 : (i == 2'd3) ? 32'd32 : 32'd16;
    endfunction
endpackage

// File: rtl/mul_share_seq_if.sv
// mul_share_seq_if: requester/response bundle of the shared multiplier sequencer
interface mul_share_seq_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic rsp_valid;
    logic rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [63:0] rsp_result;
    logic busy;
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input req_ready, rsp_valid, rsp_id, rsp_result, busy
    );
    modport slave (
        input req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, busy
    );
endinterface

// File: rtl/mul16_cell.sv
// mul16_cell: registered 16x16 unsigned multiplier with clock enable and synchronous clear
module mul16_cell (
    input logic clk,
    input logic reset,
    input logic en,
    input logic [15:0] x,
    input logic [15:0] y,
    output logic [31:0] p
);
    always_ff @(posedge clk) begin
        if (reset) p <= '0;
        else if (en) p <= 32'(x) * 32'(y);
    end
endmodule

// File: rtl/mul_share_seq.sv
// mul_share_seq: round-robin sequencer sharing one 16x16 multiplier for 32x32 products; MUL_SHARE_FULL64_EN keeps the full 64-bit product
module mul_share_seq
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input logic clk,
    input logic reset,
    mul_share_seq_if.slave bus
);
    state_t state;
    logic [ID_W-1:0] rr, gid, id;
    logic [NUM_REQ-1:0] grant;
    logic [31:0] a, b, p;
    logic [1:0] pp, acc_idx;
    logic acc_en;
    logic [ACC_W-1:0] acc;
    int idx;

    always_comb begin
        grant = '0;
        gid = '0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr) + k) % NUM_REQ;
            if (grant == '0 && bus.req_valid[idx]) begin
                grant[idx] = 1'b1;
                gid = ID_W'(idx);
            end
        end
    end

    assign bus.req_ready = (state == IDLE && !reset) ? grant : '0;
    assign bus.busy = state != IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_id = (state == RESP) ? id : '0;
    assign bus.rsp_result = (state == RESP) ? 64'(acc) : '0;

    mul16_cell u_cell (
        .clk(clk),
        .reset(reset),
        .en(state == ISSUE),
        .x(pp[1] ? a[31:16] : a[15:0]),
        .y(pp[0] ? b[31:16] : b[15:0]),
        .p(p)
    );

    // acc_en/acc_idx track which partial product sits in the cell register one cycle after issue
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr <= '0;
            id <= '0;
            a <= '0;
            b <= '0;
            pp <= '0;
            acc <= '0;
            acc_en <= 1'b0;
            acc_idx <= '0;
        end else begin
            acc_en <= state == ISSUE;
            acc_idx <= pp;
            if (acc_en) acc <= acc + ACC_W'(64'(p) << pp_shift(acc_idx));
            if (state == IDLE && |bus.req_ready) begin
                a <= bus.req_a[int'(gid)*32 +: 32];
                b <= bus.req_b[int'(gid)*32 +: 32];
                id <= gid;
                acc <= '0;
                pp <= '0;
                rr <= (int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1;
                state <= ISSUE;
            end else if (state == ISSUE) begin
                pp <= pp + 2'd1;
                if (pp == 2'(NPP - 1)) state <= DRAIN;
            end else if (state == DRAIN) state <= RESP;
            else if (state == RESP && bus.rsp_ready) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mul_share_seq.sv
// tb_mul_share_seq: directed vector bench for mul_share_seq in default or MUL_SHARE_FULL64_EN build
module tb_mul_share_seq;
`ifdef MUL_SHARE_FULL64_EN
    localparam bit FULL = 1'b1;
    localparam int LAT = 6;
`else
    localparam bit FULL = 1'b0;
    localparam int LAT = 5;
`endif
    typedef struct {
        int id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] full;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int onehot_bad = 0;
    vec_t vt[8];

    mul_share_seq_if #(.NUM_REQ(4)) bus ();
    mul_share_seq #(.NUM_REQ(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) if ($countones(bus.req_ready) > 1) onehot_bad++;

    function automatic logic [63:0] expect_of(input logic [63:0] full);
        return FULL ? full : {32'h0, full[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, output bit ok);
        bus.req_a[id*32 +: 32] = a;
        bus.req_b[id*32 +: 32] = b;
        bus.req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            ok = bus.req_ready[id];
        end
        @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 1;
        @(negedge clk);
        while (!bus.rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int cyc;
        int g;
        int seen;
        vt[0] = '{0, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008};
        vt[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vt[2] = '{2, 32'd7, 32'd6, 64'd42};
        vt[3] = '{3, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vt[4] = '{3, 32'h1234_5678, 32'h0, 64'h0};
        vt[5] = '{0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};
        vt[6] = '{1, 32'h8000_0000, 32'h2, 64'h0000_0001_0000_0000};
        vt[7] = '{2, 32'h0002_0000, 32'h3, 64'h0000_0000_0006_0000};
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        pulse_reset();
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        check("rst_rsp_id", 64'(bus.rsp_id), 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_busy", 64'(bus.busy), 0);
        @(posedge clk);
        #1;
        for (int v = 0; v < 8; v++) begin
            send(vt[v].id, vt[v].a, vt[v].b, ok);
            check($sformatf("v%0d_accept", v), 64'(ok), 1);
            wait_rsp(cyc);
            check($sformatf("v%0d_latency", v), 64'(cyc), 64'(LAT));
            check($sformatf("v%0d_id", v), 64'(bus.rsp_id), 64'(vt[v].id));
            check($sformatf("v%0d_result", v), bus.rsp_result, expect_of(vt[v].full));
            consume();
        end
        // fairness: all requesters pending from reset
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = 32'h0001_0000 + 32'(i);
            bus.req_b[i*32 +: 32] = 32'd5;
        end
        bus.req_valid = 4'hF;
        pulse_reset();
        for (int n = 0; n < 4; n++) begin
            g = -1;
            for (int t = 0; t < 30 && g < 0; t++) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) if (bus.req_ready[i]) g = i;
            end
            check($sformatf("fair%0d_grant", n), 64'(g), 64'(n));
            @(posedge clk);
            #1;
            if (g >= 0) bus.req_valid[g] = 1'b0;
            wait_rsp(cyc);
            check($sformatf("fair%0d_id", n), 64'(bus.rsp_id), 64'(n));
            check($sformatf("fair%0d_result", n), bus.rsp_result, 64'h5_0000 + 64'(5 * n));
            consume();
        end
        check("onehot_ready", 64'(onehot_bad), 0);
        // backpressure: hold RESP while requester 1 waits
        send(0, 32'd7, 32'd6, ok);
        wait_rsp(cyc);
        bus.req_a[32 +: 32] = 32'd9;
        bus.req_b[32 +: 32] = 32'd11;
        bus.req_valid[1] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.rsp_valid), 1);
            check("bp_result", bus.rsp_result, 64'd42);
            check("bp_id", 64'(bus.rsp_id), 0);
            check("bp_no_ready", 64'(bus.req_ready), 0);
        end
        consume();
        @(negedge clk);
        check("bp_next_accept", 64'(bus.req_ready), 64'b0010);
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        wait_rsp(cyc);
        check("bp_next_latency", 64'(cyc), 64'(LAT));
        check("bp_next_result", bus.rsp_result, 64'd99);
        check("bp_next_id", 64'(bus.rsp_id), 1);
        consume();
        // reset in cycle 3 of an operation
        send(2, 32'h0001_0002, 32'h0003_0004, ok);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(bus.busy), 0);
        check("mid_rst_valid", 64'(bus.rsp_valid), 0);
        check("mid_rst_result", bus.rsp_result, 0);
        check("mid_rst_id", 64'(bus.rsp_id), 0);
        check("mid_rst_ready", 64'(bus.req_ready), 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", 64'(seen), 0);
        @(posedge clk);
        #1;
        send(1, 32'd7, 32'd6, ok);
        wait_rsp(cyc);
        check("post_rst_result", bus.rsp_result, 64'd42);
        check("post_rst_id", 64'(bus.rsp_id), 1);
        consume();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mul_share_seq.md
# mul_share_seq

Sequencer and round-robin arbiter that shares one registered 16x16 unsigned multiplier among NUM_REQ requesters. Each 32x32 operand pair is decomposed into 16-bit partial products, issued one per cycle to the cell and accumulated into the product. The block sits beside the CPU multiply cell in the controlled section and serves the power-analysis accelerators, which need occasional 32-bit products without each owning DSP blocks.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of the response ID

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*32  operand A; slice i belongs to requester i
- req_b  in  NUM_REQ*32  operand B; slice i belongs to requester i
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_result  out  64  product
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: partial-product counter pp = 0..NPP-1.
  - DRAIN: last product lands.
  - RESP: hold the result.
- NPP = 3 by default; NPP = 4 with the macro below.
- Round robin:
  - Search begins at pointer rr and takes the first i with req_valid[i] set.
  - req_ready[i] = (state==IDLE) & grant[i], combinational.
  - On accept, rr <= i+1 (mod NUM_REQ), and A, B and the ID are latched.
- Requesters hold valid and data stable until ready is seen. Dropping valid before ready is legal, and no grant results.
- Partial-product issue order:
  - pp0 = a_lo*b_lo at shift 0.
  - pp1 = a_lo*b_hi at shift 16.
  - pp2 = a_hi*b_lo at shift 16.
  - pp3 = a_hi*b_hi at shift 32 (macro only).
- Accumulation:
  - acc is 64 bits, cleared on accept.
  - Each product is added in the cycle after its issue: acc <= acc + (p << shift).
  - Without the macro, acc is truncated mod 2^32 and rsp_result[63:32] = 0.
- RESP:
  - rsp_valid = 1, and rsp_result and rsp_id are stable.
  - On rsp_valid & rsp_ready the block goes to IDLE.
- Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, busy 0, rr 0, state IDLE.
- Multiplier registers are cleared by reset.
- Reset mid-operation: the operation is discarded, no response is produced, and the requester must re-request.

## Timing
- Cycle 0: accept handshake.
- Cycles 1..NPP: issue pp0..pp(NPP-1).
- Cycles 2..NPP+1: accumulate.
- Cycle NPP+2: rsp_valid rises. That is cycle 5 by default and cycle 6 with the macro.
- No accept occurs in the cycle of the rsp handshake. The earliest next accept is the following cycle, so the minimum occupancy is NPP+3 cycles per operation.
- Backpressure: rsp_ready low holds RESP indefinitely. No req_ready is asserted meanwhile.
- Multiplier cell latency is exactly 1 cycle: inputs registered at the issue edge, product valid in the next cycle.
- Simultaneous requests resolve purely by rr. A requester that is already waiting is never skipped more than NUM_REQ-1 times.

## Configuration
- MUL_SHARE_FULL64_EN:
  - Defined: pp3 is issued (NPP = 4), acc is kept at 64 bits, and rsp_result carries the full 64-bit product. Latency is 6.
  - Undefined: NPP = 3, only the low 32 bits are valid, and rsp_result[63:32] = 0. Latency is 5.

## Structure
- Package mul_share_pkg:
  - State enum (IDLE, ISSUE, DRAIN, RESP).
  - Shift constants per pp index (0, 16, 16, 32).
  - NPP localparam derived from the macro.
- Sub-module mul16_cell: registered 16x16 unsigned multiplier with 32-bit result, clock enable, and synchronous clear on reset. Instantiated once.

## Test plan
- Single request: requester 0, A = 0x00010002, B = 0x00030004.
  - Default: rsp_result = 0x00000000_000A0008, rsp_valid at cycle 5, rsp_id = 0.
  - Macro: rsp_result = 0x00000003_000A0008, rsp_valid at cycle 6.
- Overflow: A = B = 0xFFFFFFFF.
  - Default: rsp_result low word = 0x00000001.
  - Macro: rsp_result = 0xFFFFFFFE_00000001.
- Fairness: all four req_valid high from reset with distinct operands.
  - rsp_id sequence is 0, 1, 2, 3; each result is correct.
  - req_ready is never more than one-hot.
- Backpressure: rsp_ready held low for 10 cycles during RESP.
  - rsp_valid, rsp_result and rsp_id are stable throughout; no req_ready.
  - After release, the next accept occurs one cycle after the handshake.
- Reset mid-op: reset for one cycle at cycle 3 of an operation.
  - All outputs return to 0, busy is 0, and no response is produced.
  - A following request A = 7, B = 6 returns 42.
- Pointer wrap: only requester 3 requests, then requester 0.
  - Grants are 3 then 0 (rr wraps); rsp_id is 3 then 0.
